// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths,
// the control-bit bundle and small combinational helpers.
package pipe_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int REG_W_DEF    = 3;
    localparam int STALL_CNT_W  = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic halt;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // A stored control bit only means something while the slot holds a real instruction.
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic v);
        ctrl_t r;
        r.mem_read  = c.mem_read  & v;
        r.mem_write = c.mem_write & v;
        r.reg_write = c.reg_write & v;
        r.halt      = c.halt      & v;
        return r;
    endfunction

    function automatic logic store_fwd_hit(input logic mem_write, input logic wb_reg_write,
                                           input logic reg_match);
        return mem_write & wb_reg_write & reg_match;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline field register: reset beats hold, hold beats clear, clear beats load.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Select next stored value from hold / clear / load
    always_comb begin
        q_d = q_q;
        if (hold) begin
            q_d = q_q;
        end else if (clear) begin
            q_d = {W{1'b0}};
        end else begin
            q_d = d;
        end
    end

    // Field storage with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with stall, flush, halt-freeze, store-data
// forwarding from WB and a saturating stall-cycle counter.
module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_data,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_reg_write,
    input  logic              ex_halt,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              halt,
    output logic [DATA_W-1:0] alu_data,
    output logic [DATA_W-1:0] mem_writeData,
    output logic              reg_write,
    output logic [REG_W-1:0]  dest,
    output logic              valid,
    output logic [15:0]       stall_cycles
);

    ctrl_t               ex_ctrl_s;
    ctrl_t               ctrl_q;
    ctrl_t               out_ctrl_s;
    logic                valid_q;
    logic [CTRL_W:0]     ctl_bus_q;
    logic [DATA_W-1:0]   alu_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   store_sel_s;
    logic [REG_W-1:0]    dest_q;
    logic                frozen_s;
    logic                hold_s;
    logic                clear_s;
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic [STALL_CNT_W-1:0] stall_cycles_d;

    assign valid_q = ctl_bus_q[CTRL_W];
    assign ctrl_q  = ctrl_t'(ctl_bus_q[CTRL_W-1:0]);

    // Edge-action decode: freeze > flush > stall > capture (bubble when EX is empty)
    always_comb begin
        frozen_s = valid_q & ctrl_q.halt;
        hold_s   = frozen_s | (stall & ~flush);
        clear_s  = flush | ~ex_valid;
    end

    // Bundle EX control bits and pick the store value, forwarding a same-edge WB write
    always_comb begin
        ex_ctrl_s.mem_read  = ex_mem_read;
        ex_ctrl_s.mem_write = ex_mem_write;
        ex_ctrl_s.reg_write = ex_reg_write;
        ex_ctrl_s.halt      = ex_halt;
        if (store_fwd_hit(ex_mem_write, wb_reg_write, (wb_dest == ex_rt))) begin
            store_sel_s = wb_data;
        end else begin
            store_sel_s = ex_store_data;
        end
    end

    pipe_reg #(.W(CTRL_W + 1)) u_ctl_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold_s),
        .clear (clear_s),
        .d     ({1'b1, ex_ctrl_s}),
        .q     (ctl_bus_q)
    );

    pipe_reg #(.W(REG_W)) u_dest_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold_s),
        .clear (clear_s),
        .d     (ex_dest),
        .q     (dest_q)
    );

    pipe_reg #(.W(DATA_W)) u_alu_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold_s),
        .clear (clear_s),
        .d     (ex_alu_data),
        .q     (alu_q)
    );

    pipe_reg #(.W(DATA_W)) u_wdata_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold_s),
        .clear (clear_s),
        .d     (store_sel_s),
        .q     (wdata_q)
    );

    // Saturating count of stalled edges, frozen edges excluded
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !frozen_s && (stall_cycles_q != STALL_CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // Stall counter storage
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 16'h0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Drive memory-stage outputs from stored state
    always_comb begin
        out_ctrl_s    = gate_ctrl(ctrl_q, valid_q);
        mem_read      = out_ctrl_s.mem_read;
        mem_write     = out_ctrl_s.mem_write;
        reg_write     = out_ctrl_s.reg_write;
        halt          = out_ctrl_s.halt;
        valid         = valid_q;
        alu_data      = alu_q;
        mem_writeData = wdata_q;
        dest          = dest_q;
        stall_cycles  = stall_cycles_q;
    end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath and address width.
REQ-002 Parameter REG_W, default 3, register-index width.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold all pipeline state this cycle.
REQ-006 flush  input  1  load a bubble this cycle.
REQ-007 ex_valid  input  1  EX holds a real instruction.
REQ-008 ex_alu_data  input  DATA_W  ALU result / memory address.
REQ-009 ex_store_data  input  DATA_W  store data read in decode.
REQ-010 ex_rt  input  REG_W  source register of store data.
REQ-011 ex_mem_read, ex_mem_write, ex_reg_write, ex_halt  input  1 each  EX control bits.
REQ-012 ex_dest  input  REG_W  destination register.
REQ-013 wb_reg_write  input  1  WB stage writing register file.
REQ-014 wb_dest  input  REG_W  WB destination register.
REQ-015 wb_data  input  DATA_W  WB write value.
REQ-016 mem_read, mem_write, halt  output  1 each  to memory stage, gated by valid.
REQ-017 alu_data, mem_writeData  output  DATA_W  to memory stage.
REQ-018 reg_write  output  1, dest  output  REG_W, valid  output  1  forwarded to MEM/WB.
REQ-019 stall_cycles  output  16  saturating count of stalled cycles.

Function
REQ-020 Priority per edge SHALL be: rst > halt-freeze > flush > stall > capture.
REQ-021 Capture: all EX fields SHALL appear on outputs one cycle after the edge (latency 1).
REQ-022 Outputs mem_read, mem_write, reg_write, halt SHALL equal stored bit AND valid.
REQ-023 Stall (no flush): all stored fields SHALL hold unchanged.
REQ-024 Flush: valid and all control bits SHALL become 0, data fields 0, regardless of stall.
REQ-025 Store forwarding: on capture, if ex_mem_write and wb_reg_write and wb_dest == ex_rt, stored mem_writeData SHALL be wb_data, else ex_store_data.
REQ-026 Forwarding SHALL be evaluated only on capture edges, never on stall or flush edges.
REQ-027 Halt-freeze: once halt output is 1, state SHALL hold on every edge until rst, ignoring stall, flush and EX inputs.
REQ-028 stall_cycles SHALL increment on every edge with stall=1, rst=0, not frozen; SHALL saturate at 0xFFFF.
REQ-029 ex_valid=0 on capture SHALL store a bubble identical to flush.

Reset
REQ-030 On rst=1 at an edge, all outputs SHALL be 0 next cycle, including stall_cycles.
REQ-031 rst mid-freeze or mid-stall SHALL clear state in one edge; capture resumes on the following edge.

Structure
REQ-032 DATA_W, REG_W defaults and the control-bit bundle typedef SHALL live in shared package pipe_pkg.
REQ-033 Storage SHALL use one sub-module pipe_reg (parameterised width, rst/hold/clear inputs), instantiated per field group.

Verification
REQ-034 Capture: ex_valid=1, ex_alu_data=0x1234, ex_mem_read=1 -> next cycle alu_data=0x1234, mem_read=1, valid=1.
REQ-035 Stall: capture 0x00AA, then stall=1 three cycles with ex_alu_data=0x5555 -> alu_data stays 0x00AA, stall_cycles=3.
REQ-036 Flush+stall same cycle with ex_mem_write=1 -> valid=0, mem_write=0, alu_data=0.
REQ-037 Forward: ex_mem_write=1, ex_rt=3, ex_store_data=0x1111, wb_reg_write=1, wb_dest=3, wb_data=0xBEEF -> mem_writeData=0xBEEF; wb_dest=4 -> 0x1111.
REQ-038 Halt: capture ex_halt=1, then flush=1 and new EX data for 4 cycles -> halt=1 and fields unchanged; rst=1 -> all outputs 0.
REQ-039 Saturation: stall held 65540 cycles -> stall_cycles=0xFFFF, no wrap.
